ttt_game_ctrl: RTL and testbench

Parametrised N×N, K-in-a-row tic-tac-toe game controller for two players. It holds both players' boards and sequences turns through a registered FSM. It also checks move legality, detects wins and draws, and enforces an optional per-turn move timeout that forfeits the game. It sits between the player input debounce/encode logic and the display/LED driver, and replaces the per-state condition mux with a self-contained sequencer.

---
 rtl/ttt_pkg.sv | 21 ++
 rtl/ttt_win_check.sv | 47 ++++
 rtl/ttt_game_ctrl.sv | 179 +++++++++++++++++
 tb/tb_ttt_game_ctrl.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ttt_pkg.sv
// Shared definitions for the tic-tac-toe controller: FSM state encoding and
// the winner codes driven on the winner output.
package ttt_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT1,
        S_CHK1,
        S_WAIT2,
        S_CHK2,
        S_WIN1,
        S_WIN2,
        S_DRAW
    } state_t;

    localparam logic [1:0] W_NONE = 2'b00;
    localparam logic [1:0] W_P1   = 2'b01;
    localparam logic [1:0] W_P2   = 2'b10;
    localparam logic [1:0] W_DRAW = 2'b11;

endpackage

// File: rtl/ttt_win_check.sv
// Combinational K-in-a-row detector for one player's N x N occupancy map
// (row-major, bit r*N+c). Every K-long window in all four directions is ANDed.
module ttt_win_check #(
    parameter int N = 3,
    parameter int K = 3
) (
    input  logic [N*N-1:0] board,
    output logic           win
);

    localparam int NW = N - K + 1;  // window start positions per line

    logic [N*NW-1:0]  w_row;
    logic [N*NW-1:0]  w_col;
    logic [NW*NW-1:0] w_dia;
    logic [NW*NW-1:0] w_anti;

    for (genvar a = 0; a < N; a++) begin : g_line
        for (genvar b = 0; b < NW; b++) begin : g_win
            logic [K-1:0] w_r;
            logic [K-1:0] w_c;
            for (genvar t = 0; t < K; t++) begin : g_cell
                assign w_r[t] = board[a*N + b + t];
                assign w_c[t] = board[(b + t)*N + a];
            end
            assign w_row[a*NW + b] = &w_r;
            assign w_col[a*NW + b] = &w_c;
        end
    end

    // Anti-diagonal windows run from the top-right corner of each KxK square.
    for (genvar r = 0; r < NW; r++) begin : g_drow
        for (genvar c = 0; c < NW; c++) begin : g_dcol
            logic [K-1:0] w_d;
            logic [K-1:0] w_a;
            for (genvar t = 0; t < K; t++) begin : g_cell
                assign w_d[t] = board[(r + t)*N + c + t];
                assign w_a[t] = board[(r + t)*N + c + K - 1 - t];
            end
            assign w_dia[r*NW + c]  = &w_d;
            assign w_anti[r*NW + c] = &w_a;
        end
    end

    assign win = |{w_row, w_col, w_dia, w_anti};

endmodule

// File: rtl/ttt_game_ctrl.sv
// Two-player N x N, K-in-a-row game sequencer: holds both boards, validates
// moves, detects win/draw one cycle after each move and enforces a turn timeout.
module ttt_game_ctrl
    import ttt_pkg::*;
#(
    parameter int  N       = 3,
    parameter int  K       = 3,
    parameter int  TIMEOUT = 0,
    localparam int IDX_W   = $clog2(N*N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             new_game,
    input  logic             move_valid,
    input  logic [IDX_W-1:0] move_idx,
    output logic [N*N-1:0]   board_j1,
    output logic [N*N-1:0]   board_j2,
    output logic             turn,
    output logic             illegal,
    output logic             timeout,
    output logic             game_over,
    output logic [1:0]       winner
);

    localparam int               CELLS     = N * N;
    localparam int               TMR_W     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST  = (TIMEOUT > 0) ? TMR_W'(TIMEOUT - 1) : '0;
    localparam logic [IDX_W:0]   IDX_LIMIT = (IDX_W + 1)'(CELLS);
    localparam logic [CELLS-1:0] CELL_ONE  = {{(CELLS - 1){1'b0}}, 1'b1};

    state_t           r_state;
    logic [CELLS-1:0] r_board_j1;
    logic [CELLS-1:0] r_board_j2;
    logic [TMR_W-1:0] r_timer;
    logic             r_turn;
    logic             r_illegal;
    logic             r_timeout;
    logic             r_game_over;
    logic [1:0]       r_winner;

    state_t           w_state_nxt;
    logic [CELLS-1:0] w_move_mask;
    logic [CELLS-1:0] w_chk_board;
    logic             w_waiting;
    logic             w_occupied;
    logic             w_legal;
    logic             w_expire;
    logic             w_full;
    logic             w_win;
    logic [CELLS-1:0] w_b1_nxt;
    logic [CELLS-1:0] w_b2_nxt;
    logic [TMR_W-1:0] w_timer_nxt;
    logic             w_turn_nxt;
    logic             w_illegal_nxt;
    logic             w_timeout_nxt;
    logic             w_game_over_nxt;
    logic [1:0]       w_winner_nxt;

    // An out-of-range index shifts the mask to zero, so it never reads as occupied.
    assign w_move_mask = CELL_ONE << move_idx;
    assign w_waiting   = (r_state == S_WAIT1) || (r_state == S_WAIT2);
    assign w_occupied  = |((r_board_j1 | r_board_j2) & w_move_mask);
    assign w_legal     = w_waiting && move_valid && ({1'b0, move_idx} < IDX_LIMIT) && !w_occupied;
    assign w_expire    = (TIMEOUT > 0) && w_waiting && (r_timer == TMR_LAST) && !w_legal;
    assign w_full      = &(r_board_j1 | r_board_j2);
    assign w_chk_board = (r_state == S_CHK2) ? r_board_j2 : r_board_j1;

    ttt_win_check #(
        .N (N),
        .K (K)
    ) u_win_check (
        .board (w_chk_board),
        .win   (w_win)
    );

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        if (new_game) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (start) w_state_nxt = S_WAIT1;
                S_WAIT1: begin
                    if (w_legal)       w_state_nxt = S_CHK1;
                    else if (w_expire) w_state_nxt = S_WIN2;
                end
                S_WAIT2: begin
                    if (w_legal)       w_state_nxt = S_CHK2;
                    else if (w_expire) w_state_nxt = S_WIN1;
                end
                S_CHK1: begin
                    if (w_win)       w_state_nxt = S_WIN1;
                    else if (w_full) w_state_nxt = S_DRAW;
                    else             w_state_nxt = S_WAIT2;
                end
                S_CHK2: begin
                    if (w_win)       w_state_nxt = S_WIN2;
                    else if (w_full) w_state_nxt = S_DRAW;
                    else             w_state_nxt = S_WAIT1;
                end
                default: w_state_nxt = r_state;
            endcase
        end
    end

    always_comb begin
        w_b1_nxt      = r_board_j1;
        w_b2_nxt      = r_board_j2;
        w_timer_nxt   = '0;
        w_illegal_nxt = 1'b0;
        w_timeout_nxt = 1'b0;
        if (new_game) begin
            w_b1_nxt = '0;
            w_b2_nxt = '0;
        end else if (w_waiting) begin
            if (w_legal) begin
                if (r_state == S_WAIT1) w_b1_nxt = r_board_j1 | w_move_mask;
                else                    w_b2_nxt = r_board_j2 | w_move_mask;
            end else begin
                w_illegal_nxt = move_valid;
                w_timeout_nxt = w_expire;
                if ((TIMEOUT > 0) && !w_expire) w_timer_nxt = r_timer + 1'b1;
            end
        end

        // Status outputs are decoded from the next state so they register with it.
        w_turn_nxt      = (w_state_nxt == S_WAIT2) || (w_state_nxt == S_CHK2);
        w_game_over_nxt = (w_state_nxt == S_WIN1) || (w_state_nxt == S_WIN2) ||
                          (w_state_nxt == S_DRAW);
        case (w_state_nxt)
            S_WIN1:  w_winner_nxt = W_P1;
            S_WIN2:  w_winner_nxt = W_P2;
            S_DRAW:  w_winner_nxt = W_DRAW;
            default: w_winner_nxt = W_NONE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_board_j1  <= '0;
            r_board_j2  <= '0;
            r_timer     <= '0;
            r_turn      <= 1'b0;
            r_illegal   <= 1'b0;
            r_timeout   <= 1'b0;
            r_game_over <= 1'b0;
            r_winner    <= W_NONE;
        end else begin
            r_board_j1  <= w_b1_nxt;
            r_board_j2  <= w_b2_nxt;
            r_timer     <= w_timer_nxt;
            r_turn      <= w_turn_nxt;
            r_illegal   <= w_illegal_nxt;
            r_timeout   <= w_timeout_nxt;
            r_game_over <= w_game_over_nxt;
            r_winner    <= w_winner_nxt;
        end
    end

    assign board_j1  = r_board_j1;
    assign board_j2  = r_board_j2;
    assign turn      = r_turn;
    assign illegal   = r_illegal;
    assign timeout   = r_timeout;
    assign game_over = r_game_over;
    assign winner    = r_winner;

endmodule

// File: tb/tb_ttt_game_ctrl.sv
// Scoreboard bench for ttt_game_ctrl: three configurations (3x3, 3x3 with timeout,
// 4x4 K=3) share stimulus; expected events are queued and checked by a monitor.
module tb_ttt_game_ctrl;

    localparam int EV_ILL  = 0;
    localparam int EV_TO   = 1;
    localparam int EV_OVER = 2;

    typedef struct {
        int          kind;
        logic [1:0]  win;
        logic [15:0] b1;
        logic [15:0] b2;
        int          cyc;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       new_game = 1'b0;
    logic       move_valid = 1'b0;
    logic [3:0] move_idx = '0;
    logic [2:0] start_v = '0;

    logic [8:0]  a_b1, a_b2, t_b1, t_b2;
    logic [15:0] f_b1, f_b2;
    logic a_turn, a_ill, a_to, a_go, t_turn, t_ill, t_to, t_go, f_turn, f_ill, f_to, f_go;
    logic [1:0] a_win, t_win, f_win;

    int  n_vec = 0;
    int  n_err = 0;
    int  cyc = 0;
    int  sel = 0;
    ev_t q[$];

    int seq_win[5]  = '{0, 3, 1, 4, 2};
    int seq_draw[9] = '{0, 1, 2, 4, 3, 5, 7, 6, 8};
    int seq_full[9] = '{0, 1, 2, 3, 7, 4, 5, 6, 8};
    int seq_n4[5]   = '{1, 0, 6, 4, 11};

    ttt_game_ctrl #(.N(3), .K(3), .TIMEOUT(0)) u_a (
        .clk(clk), .rst(rst), .start(start_v[0]), .new_game(new_game),
        .move_valid(move_valid), .move_idx(move_idx),
        .board_j1(a_b1), .board_j2(a_b2), .turn(a_turn), .illegal(a_ill),
        .timeout(a_to), .game_over(a_go), .winner(a_win)
    );

    ttt_game_ctrl #(.N(3), .K(3), .TIMEOUT(10)) u_t (
        .clk(clk), .rst(rst), .start(start_v[1]), .new_game(new_game),
        .move_valid(move_valid), .move_idx(move_idx),
        .board_j1(t_b1), .board_j2(t_b2), .turn(t_turn), .illegal(t_ill),
        .timeout(t_to), .game_over(t_go), .winner(t_win)
    );

    ttt_game_ctrl #(.N(4), .K(3), .TIMEOUT(0)) u_f (
        .clk(clk), .rst(rst), .start(start_v[2]), .new_game(new_game),
        .move_valid(move_valid), .move_idx(move_idx),
        .board_j1(f_b1), .board_j2(f_b2), .turn(f_turn), .illegal(f_ill),
        .timeout(f_to), .game_over(f_go), .winner(f_win)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: any illegal/timeout pulse or rising game_over is an output event.
    always @(negedge clk) begin : mon
        logic        ill, to, go;
        logic [1:0]  win;
        logic [15:0] b1, b2;
        logic        go_prev;
        int          kind;
        ev_t         e;
        case (sel)
            0:       begin ill = a_ill; to = a_to; go = a_go; win = a_win; b1 = {7'd0, a_b1}; b2 = {7'd0, a_b2}; end
            1:       begin ill = t_ill; to = t_to; go = t_go; win = t_win; b1 = {7'd0, t_b1}; b2 = {7'd0, t_b2}; end
            default: begin ill = f_ill; to = f_to; go = f_go; win = f_win; b1 = f_b1; b2 = f_b2; end
        endcase
        if (ill || to || (go && !go_prev)) begin
            kind = ill ? EV_ILL : (to ? EV_TO : EV_OVER);
            if (q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_event: actual kind=%0d expected none (cycle %0d)", kind, cyc);
            end else begin
                e = q.pop_front();
                check("ev_kind", kind, e.kind);
                check("ev_cycle", cyc, e.cyc);
                check("ev_winner", {30'd0, win}, {30'd0, e.win});
                check("ev_game_over", {31'd0, go}, {31'd0, (e.kind != EV_ILL)});
                check("ev_board_j1", {16'd0, b1}, {16'd0, e.b1});
                check("ev_board_j2", {16'd0, b2}, {16'd0, e.b2});
            end
        end
        go_prev = go;
    end

    task automatic expect_ev(input int kind, input logic [1:0] win,
                             input logic [15:0] b1, input logic [15:0] b2, input int lat);
        ev_t e;
        e.kind = kind; e.win = win; e.b1 = b1; e.b2 = b2; e.cyc = cyc + lat;
        q.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start(input int s);
        sel = s;
        start_v[s] = 1'b1;
        @(negedge clk);
        start_v = '0;
    endtask

    task automatic move(input int idx);
        move_valid = 1'b1;
        move_idx = 4'(idx);
        @(negedge clk);
        move_valid = 1'b0;
    endtask

    // A legal move spends one cycle in WAIT and one in CHK.
    task automatic play(input int idx);
        move(idx);
        tick(1);
    endtask

    task automatic restart();
        new_game = 1'b1;
        @(negedge clk);
        new_game = 1'b0;
    endtask

    task automatic settle();
        tick(3);
        check("queue_empty", q.size(), 0);
        q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        #1 rst = 1'b1;
        #1;
        check("rst_board_j1", {23'd0, a_b1}, 32'h0);
        check("rst_game_over", {31'd0, a_go}, 32'h0);
        check("rst_winner", {30'd0, a_win}, 32'h0);
        check("rst_turn", {31'd0, a_turn}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        tick(1);

        // P1 wins the top row.
        pulse_start(0);
        for (int i = 0; i < 5; i++) begin
            if (i == 4) expect_ev(EV_OVER, 2'b01, 16'h007, 16'h018, 2);
            play(seq_win[i]);
        end
        settle();
        restart();

        // Occupied cell and out-of-range index are both rejected.
        pulse_start(0);
        play(4);
        expect_ev(EV_ILL, 2'b00, 16'h010, 16'h000, 1);
        move(4);
        tick(1);
        check("ill_turn_stays_p2", {31'd0, a_turn}, 32'h1);
        check("ill_board_j2", {23'd0, a_b2}, 32'h0);
        expect_ev(EV_ILL, 2'b00, 16'h010, 16'h000, 1);
        move(9);
        move(0);
        check("legal_after_ill_j2", {23'd0, a_b2}, 32'h001);
        tick(1);
        check("turn_back_p1", {31'd0, a_turn}, 32'h0);
        settle();
        restart();

        // Draw.
        pulse_start(0);
        for (int i = 0; i < 9; i++) begin
            if (i == 8) expect_ev(EV_OVER, 2'b11, 16'h18D, 16'h072, 2);
            play(seq_draw[i]);
        end
        settle();
        restart();

        // Winning move that also fills the board reports the win.
        pulse_start(0);
        for (int i = 0; i < 9; i++) begin
            if (i == 8) expect_ev(EV_OVER, 2'b01, 16'h1A5, 16'h05A, 2);
            play(seq_full[i]);
        end
        move(6);
        check("terminal_holds_j1", {23'd0, a_b1}, 32'h1A5);
        settle();
        restart();

        // Timeout: P1 idles for 10 cycles.
        expect_ev(EV_TO, 2'b10, 16'h000, 16'h000, 11);
        pulse_start(1);
        tick(12);
        settle();
        restart();

        // Move on the last allowed cycle is accepted; P2 then gets a fresh timer.
        pulse_start(1);
        tick(9);
        move(0);
        check("late_move_j1", {23'd0, t_b1}, 32'h001);
        check("late_move_no_over", {31'd0, t_go}, 32'h0);
        expect_ev(EV_TO, 2'b01, 16'h001, 16'h000, 11);
        tick(12);
        settle();
        restart();

        // Asynchronous reset mid-game.
        pulse_start(0);
        play(0); play(4); play(8);
        check("mid_board_j1", {23'd0, a_b1}, 32'h101);
        #2 rst = 1'b1;
        #1;
        check("async_rst_j1", {23'd0, a_b1}, 32'h0);
        check("async_rst_j2", {23'd0, a_b2}, 32'h0);
        check("async_rst_turn", {31'd0, a_turn}, 32'h0);
        #1 rst = 1'b0;
        tick(1);

        // new_game mid-game clears on the next edge and returns to IDLE.
        pulse_start(0);
        play(0); play(4); play(8);
        check("mid2_board_j2", {23'd0, a_b2}, 32'h010);
        restart();
        check("ng_board_j1", {23'd0, a_b1}, 32'h0);
        check("ng_board_j2", {23'd0, a_b2}, 32'h0);
        check("ng_turn", {31'd0, a_turn}, 32'h0);
        move(0);
        check("idle_ignores_move", {23'd0, a_b1}, 32'h0);

        // move_valid together with start is ignored.
        start_v[0] = 1'b1;
        move_valid = 1'b1;
        move_idx = 4'd2;
        @(negedge clk);
        start_v = '0;
        move_valid = 1'b0;
        tick(2);
        check("start_move_ignored", {23'd0, a_b1}, 32'h0);
        settle();
        restart();

        // 4x4, K=3: P1 completes the diagonal window starting at (0,1).
        pulse_start(2);
        for (int i = 0; i < 5; i++) begin
            if (i == 4) expect_ev(EV_OVER, 2'b01, 16'h0842, 16'h0011, 2);
            play(seq_n4[i]);
        end
        settle();
        restart();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
